pueo_trig_sequencer: RTL and testbench

Single-clock memclk-domain trigger sequencer. It is the parametrised successor to the aclk trigger-time path and async address FIFO in front of the URAM readout. It accepts trigger times, applies a pre-trigger offset and holdoff, and numbers events. It queues pending readouts and generates the per-beat URAM read-address stream, with begin and last framing, for the event buffer.

---
 rtl/pueo_trig_sequencer_pkg.sv | 21 ++
 rtl/pueo_trig_sequencer_fifo.sv | 70 +++++++
 rtl/pueo_trig_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pueo_trig_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_trig_sequencer_pkg.sv
// Shared types for the memclk trigger sequencer: queue entry layout and readout FSM states.
package pueo_trig_pkg;

    localparam int ADDR_BITS_DEF  = 16;
    localparam int DEPTH_LOG2_DEF = 4;
    localparam int EVNUM_BITS_DEF = 16;
    localparam int LEN_BITS_DEF   = 10;

    typedef struct packed {
        logic [EVNUM_BITS_DEF-1:0] evnum;
        logic [ADDR_BITS_DEF-1:0]  addr;
    } trig_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        BURST = 2'd2,
        GAP   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pueo_trig_sequencer_fifo.sv
// Single-clock distributed-RAM FIFO: asynchronous head read, registered count/full/empty, sync flush.
module trig_queue_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  memclk_i,
    input  logic                  memclk_rst_i,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    // NOTE: the storage array has no reset; only the pointers do, and slots past count are never read.
    always_ff @(posedge memclk_i) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_COUNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/pueo_trig_sequencer.sv
// Trigger sequencer: offset/holdoff/numbering of triggers, readout queue and URAM address bursts.
// Optional drop counters and queue high-water mark under `define PUEO_TRIG_SEQ_STATS_EN.
module pueo_trig_sequencer
    import pueo_trig_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int EVNUM_BITS = 16,
    parameter int LEN_BITS   = 10
) (
    input  logic                  memclk_i,
    input  logic                  memclk_rst_i,
    input  logic                  run_rst_i,
    input  logic                  run_stop_i,
    input  logic [ADDR_BITS-1:0]  trig_time_i,
    input  logic                  trig_valid_i,
    input  logic [ADDR_BITS-1:0]  offset_i,
    input  logic [LEN_BITS-1:0]   len_i,
    input  logic [15:0]           holdoff_i,
    output logic [ADDR_BITS-1:0]  rd_addr_o,
    output logic [EVNUM_BITS-1:0] rd_evnum_o,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic                  rd_begin_o,
    output logic                  rd_last_o,
    output logic [DEPTH_LOG2:0]   q_count_o,
    output logic                  full_o,
    output logic                  running_o
`ifdef PUEO_TRIG_SEQ_STATS_EN
    ,
    output logic [15:0]           drop_full_cnt_o,
    output logic [15:0]           drop_holdoff_cnt_o,
    output logic [DEPTH_LOG2:0]   hwm_o
`endif
);

    localparam int ENTRY_BITS = EVNUM_BITS + ADDR_BITS;

    logic                  running;
    logic [EVNUM_BITS-1:0] evnum;
    logic [15:0]           holdoff_cnt;
    logic                  trig_seen;
    logic                  push;
    logic                  pop;
    logic [ENTRY_BITS-1:0] push_data;
    logic [ENTRY_BITS-1:0] head;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  empty;

    seq_state_t            state;
    logic [ADDR_BITS-1:0]  addr;
    logic [EVNUM_BITS-1:0] cur_evnum;
    logic [LEN_BITS-1:0]   beats_left;
    logic                  first_beat;

    // A trigger during run_rst_i is discarded along with everything else being cleared.
    assign trig_seen = trig_valid_i && running && !run_rst_i;
    assign push      = trig_seen && !full && (holdoff_cnt == '0);
    assign push_data = {evnum, trig_time_i - offset_i};
    assign pop       = (state == LOAD);

    trig_queue_fifo #(
        .WIDTH      (ENTRY_BITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_queue (
        .memclk_i     (memclk_i),
        .memclk_rst_i (memclk_rst_i),
        .flush        (run_rst_i),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .head         (head),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            running     <= 1'b0;
            evnum       <= '0;
            holdoff_cnt <= '0;
        end else begin
            running <= run_stop_i ? 1'b0 : (run_rst_i ? 1'b1 : running);
            if (run_rst_i) begin
                evnum       <= '0;
                holdoff_cnt <= '0;
            end else begin
                if (trig_seen)
                    evnum <= evnum + 1'b1;
                if (push)
                    holdoff_cnt <= holdoff_i;
                else if (holdoff_cnt != '0)
                    holdoff_cnt <= holdoff_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            state      <= IDLE;
            addr       <= '0;
            cur_evnum  <= '0;
            beats_left <= '0;
            first_beat <= 1'b0;
        end else if (run_rst_i) begin
            state      <= IDLE;
            first_beat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= LOAD;
                LOAD: begin
                    addr       <= head[ADDR_BITS-1:0];
                    cur_evnum  <= head[ENTRY_BITS-1:ADDR_BITS];
                    beats_left <= len_i;
                    first_beat <= 1'b1;
                    state      <= BURST;
                end
                BURST: if (rd_ready_i) begin
                    first_beat <= 1'b0;
                    if (beats_left == '0) begin
                        state <= GAP;
                    end else begin
                        addr       <= addr + 1'b1;
                        beats_left <= beats_left - 1'b1;
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_valid_o = (state == BURST);
    assign rd_begin_o = rd_valid_o && first_beat;
    assign rd_last_o  = rd_valid_o && (beats_left == '0);
    assign rd_addr_o  = addr;
    assign rd_evnum_o = cur_evnum;
    assign q_count_o  = count;
    assign full_o     = full;
    assign running_o  = running;

`ifdef PUEO_TRIG_SEQ_STATS_EN
    always_ff @(posedge memclk_i or posedge memclk_rst_i) begin
        if (memclk_rst_i) begin
            drop_full_cnt_o    <= '0;
            drop_holdoff_cnt_o <= '0;
            hwm_o              <= '0;
        end else if (run_rst_i) begin
            drop_full_cnt_o    <= '0;
            drop_holdoff_cnt_o <= '0;
            hwm_o              <= '0;
        end else begin
            // A trigger lost to both causes is charged to the full queue.
            if (trig_seen && full && (drop_full_cnt_o != 16'hFFFF))
                drop_full_cnt_o <= drop_full_cnt_o + 1'b1;
            if (trig_seen && !full && (holdoff_cnt != '0) && (drop_holdoff_cnt_o != 16'hFFFF))
                drop_holdoff_cnt_o <= drop_holdoff_cnt_o + 1'b1;
            if (count > hwm_o)
                hwm_o <= count;
        end
    end
`endif

endmodule

// File: tb/tb_pueo_trig_sequencer.sv
// Scoreboard bench for pueo_trig_sequencer: directed scenarios plus randomized traffic.
module tb_pueo_trig_sequencer;
    import pueo_trig_pkg::*;

    localparam int DL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_rst, run_stop, trig_valid, rd_ready;
    logic [15:0] trig_time, offset, holdoff;
    logic [9:0]  len;
    logic [15:0] rd_addr, rd_evnum;
    logic        rd_valid, rd_begin, rd_last, full, running;
    logic [DL:0] q_count;
`ifdef PUEO_TRIG_SEQ_STATS_EN
    logic [15:0] drop_full_cnt, drop_holdoff_cnt;
    logic [DL:0] hwm;
`endif

    always #5 clk = ~clk;

    pueo_trig_sequencer #(
        .ADDR_BITS (16), .DEPTH_LOG2 (DL), .EVNUM_BITS (16), .LEN_BITS (10)
    ) dut (
        .memclk_i     (clk),
        .memclk_rst_i (rst),
        .run_rst_i    (run_rst),
        .run_stop_i   (run_stop),
        .trig_time_i  (trig_time),
        .trig_valid_i (trig_valid),
        .offset_i     (offset),
        .len_i        (len),
        .holdoff_i    (holdoff),
        .rd_addr_o    (rd_addr),
        .rd_evnum_o   (rd_evnum),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_begin_o   (rd_begin),
        .rd_last_o    (rd_last),
        .q_count_o    (q_count),
        .full_o       (full),
        .running_o    (running)
`ifdef PUEO_TRIG_SEQ_STATS_EN
        ,
        .drop_full_cnt_o    (drop_full_cnt),
        .drop_holdoff_cnt_o (drop_holdoff_cnt),
        .hwm_o              (hwm)
`endif
    );

    typedef struct {
        trig_entry_t e;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   beat_idx = 0;
    int   total = 0;
    int   bad = 0;

    // Reference model state: run flag, next event number, time and holdoff of the last accept.
    bit          m_running = 1'b0;
    logic [15:0] m_evnum = '0;
    bit          m_have = 1'b0;
    int          m_last = 0;
    int          m_h = 0;
    int          t = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock of stimulus; mfull tells the model the queue is known to be full this cycle.
    task automatic step(input bit trig, input logic [15:0] tt, input bit rr, input bit rs,
                        input bit rdy, input bit mfull);
        exp_t x;
        trig_valid = trig;
        trig_time  = tt;
        run_rst    = rr;
        run_stop   = rs;
        rd_ready   = rdy && !rr;
        if (rr) begin
            sb.delete();
            beat_idx  = 0;
            m_evnum   = '0;
            m_have    = 1'b0;
            m_running = !rs;
        end else begin
            if (m_running && trig) begin
                if (!mfull && (!m_have || (t - m_last) >= m_h + 1)) begin
                    x.e.evnum = m_evnum;
                    x.e.addr  = tt - offset;
                    x.len     = int'(len);
                    sb.push_back(x);
                    m_have = 1'b1;
                    m_last = t;
                    m_h    = int'(holdoff);
                end
                m_evnum = m_evnum + 16'd1;
            end
            if (rs) m_running = 1'b0;
        end
        @(posedge clk);
        #1;
        t++;
        trig_valid = 1'b0;
        run_rst    = 1'b0;
        run_stop   = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            step(1'b0, 16'd0, 1'b0, 1'b0, $urandom_range(0, 3) != 0, 1'b0);
            n++;
        end
        check("drain_done", sb.size(), 0);
        repeat (4) step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: every accepted beat is compared against the head of the scoreboard.
    initial begin
        logic [15:0] ea;
        forever begin
            @(negedge clk);
            if (!rst && rd_valid && rd_ready) begin
                check("beat_has_pending_event", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    ea = sb[0].e.addr + 16'(beat_idx);
                    check("beat_addr", rd_addr, ea);
                    check("beat_evnum", rd_evnum, sb[0].e.evnum);
                    check("beat_begin", rd_begin, beat_idx == 0);
                    check("beat_last", rd_last, beat_idx == sb[0].len);
                    if (beat_idx == sb[0].len) begin
                        void'(sb.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run_rst = 1'b0; run_stop = 1'b0; trig_valid = 1'b0; rd_ready = 1'b0;
        trig_time = '0; offset = '0; holdoff = '0; len = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rd_valid, 0);
        check("rst_count", q_count, 0);
        check("rst_running", running, 0);
        check("rst_full", full, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_evnum", rd_evnum, 0);
        check("rst_framing", {rd_begin, rd_last}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First event: latency, wrapped start address, stall stability.
        offset = 16'd100;
        len    = 10'd3;
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("running_after_run_rst", running, 1);
        step(1'b1, 16'd50, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("valid_low_in_load", rd_valid, 0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("first_valid_n3", rd_valid, 1);
        check("first_addr", rd_addr, 65486);
        check("first_begin", rd_begin, 1);
        check("first_evnum", rd_evnum, 0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) begin
            step(1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_addr", rd_addr, 65488);
            check("stall_valid", rd_valid, 1);
        end
        drain();

        // Holdoff: triggers at N, N+5, N+11 with holdoff 10.
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        offset  = 16'd0;
        len     = 10'd1;
        holdoff = 16'd10;
        step(1'b1, 16'd1000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'd2000, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'd3000, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
`ifdef PUEO_TRIG_SEQ_STATS_EN
        check("drop_holdoff_cnt", drop_holdoff_cnt, 1);
        check("drop_full_cnt_zero", drop_full_cnt, 0);
`endif
        holdoff = 16'd0;

        // Queue full: six back-to-back triggers with readout stalled; the sixth is dropped.
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b1, 16'(i * 7 + 3), 1'b0, 1'b0, 1'b0, i == 5);
        check("full_flag", full, 1);
        check("full_count", q_count, 4);
`ifdef PUEO_TRIG_SEQ_STATS_EN
        check("drop_full_cnt", drop_full_cnt, 1);
        check("hwm", hwm, 4);
`endif
        drain();
        check("count_after_full_drain", q_count, 0);

        // Stop with two events queued: both drain, a later trigger is ignored.
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        len = 10'd2;
        step(1'b1, 16'd400, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("running_after_stop", running, 0);
        step(1'b1, 16'd555, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();
        check("count_after_stop_drain", q_count, 0);

        // run_rst in the middle of a burst with a second event queued.
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        len = 10'd7;
        step(1'b1, 16'd700, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'd800, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("burst_active_before_abort", rd_valid, 1);
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("abort_valid", rd_valid, 0);
        check("abort_count", q_count, 0);
        step(1'b1, 16'd900, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();

        // Randomized traffic; at most three events outstanding so the queue never fills.
        step(1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            bit trig;
            trig = ($urandom_range(0, 2) == 0) && (sb.size() < 3);
            if (sb.size() == 0 && !trig && $urandom_range(0, 7) == 0)
                len = 10'($urandom_range(0, 5));
            if ($urandom_range(0, 15) == 0)
                offset = 16'($urandom);
            if ($urandom_range(0, 9) == 0)
                holdoff = 16'($urandom_range(0, 6));
            step(trig, 16'($urandom), 1'b0, 1'b0, $urandom_range(0, 9) < 7, 1'b0);
        end
        drain();
        check("final_count", q_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
